// File: rtl/pc_pkg.sv
// Shared types for the program-counter unit: next-PC source select and the
// single-operation command word of the return-address stack.
package pc_pkg;

    // Source of the next fetch PC, in decreasing priority after SEL_RESET
    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_EXC,
        SEL_REDIR,
        SEL_HOLD,
        SEL_CALLRET,
        SEL_CALL,
        SEL_RET,
        SEL_SEQ
    } next_sel_e;

    // One operation per cycle on the return-address stack
    typedef enum logic [2:0] {
        NOP,
        PUSH,
        POP,
        REPLACE,
        CLEAR
    } ras_op_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. ptr_q points at the next free slot, so the
// top of stack is ptr_q-1. A push on a full stack lands on the oldest entry
// because the pointer has wrapped onto it; the count saturates at DEPTH.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  ras_op_e                      op_i,
    input  logic [W-1:0]                 wdata_i,
    output logic [W-1:0]                 top_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         empty_o,
    output logic                         full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];
    logic [PTR_W-1:0] top_ptr;

    // Top entry sits one below the write pointer (wraps modulo DEPTH)
    always_comb begin
        top_ptr = ptr_q - PTR_W'(1);
    end

    // Next-state of pointer, count and storage for the requested operation
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        mem_d = mem_q;
        case (op_i)
            PUSH: begin
                mem_d[ptr_q] = wdata_i;
                ptr_d        = ptr_q + PTR_W'(1);
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            POP: begin
                if (cnt_q != '0) begin
                    ptr_d = ptr_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            REPLACE: begin
                if (cnt_q != '0) begin
                    mem_d[top_ptr] = wdata_i;
                end
            end
            CLEAR: begin
                ptr_d = '0;
                cnt_d = '0;
            end
            default: begin
                ptr_d = ptr_q;
            end
        endcase
    end

    // Pointer and count registers; contents are don't-care after reset
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack storage, no reset needed
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    // Status outputs decoded from the registered count
    always_comb begin
        top_o   = mem_q[top_ptr];
        count_o = cnt_q;
        empty_o = (cnt_q == '0);
        full_o  = (cnt_q == CNT_MAX);
    end

endmodule

// File: rtl/pc_unit.sv
// Fetch program counter with fixed-priority next-PC selection and a small
// return-address stack used to predict return targets.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned    PC_W        = 32,
    parameter logic [PC_W-1:0] RESET_PC   = '0,
    parameter int unsigned    INSTR_BYTES = 4,
    parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(32'h0000_0080),
    parameter int unsigned    RAS_DEPTH   = 4
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic                               stall_i,
    input  logic                               pc_enable_i,
    input  logic                               exc_i,
    input  logic                               redirect_i,
    input  logic [PC_W-1:0]                    redirect_pc_i,
    input  logic                               call_i,
    input  logic                               ret_i,
    input  logic [PC_W-1:0]                    target_i,
    output logic [PC_W-1:0]                    pc_o,
    output logic [PC_W-1:0]                    pc_plus_o,
    output logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count_o,
    output logic                               ras_empty_o,
    output logic                               ras_full_o,
    output logic                               ras_underflow_o
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic            underflow_q, underflow_d;
    logic [PC_W-1:0] pc_plus;
    next_sel_e       sel;
    ras_op_e         ras_op;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;

    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .op_i    (ras_op),
        .wdata_i (pc_plus),
        .top_o   (ras_top),
        .count_o (ras_count_o),
        .empty_o (ras_empty),
        .full_o  (ras_full_o)
    );

    // Sequential successor, modulo 2^PC_W
    always_comb begin
        pc_plus = pc_q + PC_W'(INSTR_BYTES);
    end

    // Priority decoder: start low beats everything, then exc, redirect, holds
    always_comb begin
        sel = SEL_SEQ;
        if (!start_i) begin
            sel = SEL_RESET;
        end else if (exc_i) begin
            sel = SEL_EXC;
        end else if (redirect_i) begin
            sel = SEL_REDIR;
        end else if (stall_i || !pc_enable_i) begin
            sel = SEL_HOLD;
        end else if (call_i && ret_i) begin
            sel = SEL_CALLRET;
        end else if (call_i) begin
            sel = SEL_CALL;
        end else if (ret_i) begin
            sel = SEL_RET;
        end
    end

    // Next PC, RAS operation and underflow flag for the selected source
    always_comb begin
        pc_d        = pc_q;
        ras_op      = NOP;
        underflow_d = 1'b0;
        case (sel)
            SEL_RESET: begin
                pc_d   = RESET_PC;
                ras_op = CLEAR;
            end
            SEL_EXC: begin
                pc_d   = EXC_VECTOR;
                ras_op = CLEAR;
            end
            SEL_REDIR: begin
                pc_d = redirect_pc_i;
            end
            SEL_HOLD: begin
                pc_d = pc_q;
            end
            SEL_CALLRET: begin
                // Return to the predicted target while the call's own link
                // replaces it; with nothing to return to, behave as a push.
                if (!ras_empty) begin
                    pc_d   = ras_top;
                    ras_op = REPLACE;
                end else begin
                    pc_d        = pc_plus;
                    ras_op      = PUSH;
                    underflow_d = 1'b1;
                end
            end
            SEL_CALL: begin
                pc_d   = target_i;
                ras_op = PUSH;
            end
            SEL_RET: begin
                if (!ras_empty) begin
                    pc_d   = ras_top;
                    ras_op = POP;
                end else begin
                    pc_d        = pc_plus;
                    underflow_d = 1'b1;
                end
            end
            default: begin
                pc_d = pc_plus;
            end
        endcase
    end

    // PC and underflow-pulse registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pc_q        <= RESET_PC;
            underflow_q <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            underflow_q <= underflow_d;
        end
    end

    // Output drive
    always_comb begin
        pc_o            = pc_q;
        pc_plus_o       = pc_plus;
        ras_empty_o     = ras_empty;
        ras_underflow_o = underflow_q;
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed and randomized bench for pc_unit against a queue-based reference.
module tb_pc_unit;
    logic        clk;
    logic        rst_i;
    logic        start_i, stall_i, pc_enable_i, exc_i, redirect_i, call_i, ret_i;
    logic [31:0] redirect_pc_i, target_i;
    logic [31:0] pc_o, pc_plus_o;
    logic [2:0]  ras_count_o;
    logic        ras_empty_o, ras_full_o, ras_underflow_o;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: PC value, return stack as a bounded queue, underflow
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_uf;

    pc_unit dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .stall_i         (stall_i),
        .pc_enable_i     (pc_enable_i),
        .exc_i           (exc_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .call_i          (call_i),
        .ret_i           (ret_i),
        .target_i        (target_i),
        .pc_o            (pc_o),
        .pc_plus_o       (pc_plus_o),
        .ras_count_o     (ras_count_o),
        .ras_empty_o     (ras_empty_o),
        .ras_full_o      (ras_full_o),
        .ras_underflow_o (ras_underflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".pc"},    pc_o,                   m_pc);
        chk({tag, ".plus"},  pc_plus_o,              m_pc + 32'd4);
        chk({tag, ".count"}, {29'd0, ras_count_o},   m_ras.size());
        chk({tag, ".empty"}, {31'd0, ras_empty_o},   {31'd0, m_ras.size() == 0});
        chk({tag, ".full"},  {31'd0, ras_full_o},    {31'd0, m_ras.size() == 4});
        chk({tag, ".uf"},    {31'd0, ras_underflow_o}, {31'd0, m_uf});
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        m_ras.delete();
        m_uf = 1'b0;
    endtask

    // Apply the priority rules to the current inputs at one rising edge
    task automatic model_edge();
        logic [31:0] nxt;
        logic        uf;
        nxt = m_pc;
        uf  = 1'b0;
        if (!start_i) begin
            nxt = 32'd0;
            m_ras.delete();
        end else if (exc_i) begin
            nxt = 32'h80;
            m_ras.delete();
        end else if (redirect_i) begin
            nxt = redirect_pc_i;
        end else if (stall_i || !pc_enable_i) begin
            nxt = m_pc;
        end else if (call_i && ret_i) begin
            if (m_ras.size() > 0) begin
                nxt = m_ras[m_ras.size() - 1];
                m_ras[m_ras.size() - 1] = m_pc + 32'd4;
            end else begin
                m_ras.push_back(m_pc + 32'd4);
                nxt = m_pc + 32'd4;
                uf  = 1'b1;
            end
        end else if (call_i) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
            nxt = target_i;
        end else if (ret_i) begin
            if (m_ras.size() > 0) nxt = m_ras.pop_back();
            else begin
                nxt = m_pc + 32'd4;
                uf  = 1'b1;
            end
        end else begin
            nxt = m_pc + 32'd4;
        end
        m_pc = nxt;
        m_uf = uf;
    endtask

    task automatic cyc(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    task automatic idle();
        start_i = 1'b1; stall_i = 1'b0; pc_enable_i = 1'b1; exc_i = 1'b0;
        redirect_i = 1'b0; call_i = 1'b0; ret_i = 1'b0;
        redirect_pc_i = 32'd0; target_i = 32'd0;
    endtask

    initial begin
        idle();
        start_i = 1'b0;
        rst_i   = 1'b1;
        #2 rst_i = 1'b0;
        model_reset();
        #10;
        chk_all("reset");
        chk("reset.pc_lit", pc_o, 32'd0);

        // Release reset between edges, then run sequentially
        @(negedge clk);
        rst_i = 1'b1;
        idle();
        cyc("run1"); cyc("run2"); cyc("run3");
        chk("run.pc_lit", pc_o, 32'hC);
        start_i = 1'b0;
        cyc("stop");
        chk("stop.pc_lit", pc_o, 32'd0);
        start_i = 1'b1;

        // Stall with call asserted holds PC and RAS
        cyc("seq4"); cyc("seq8");
        stall_i = 1'b1; call_i = 1'b1; target_i = 32'h500;
        cyc("stall1"); cyc("stall2");
        chk("stall.pc_lit", pc_o, 32'h8);
        idle();
        cyc("unstall");
        chk("unstall.pc_lit", pc_o, 32'hC);
        cyc("to10");

        // Call then return
        call_i = 1'b1; target_i = 32'h100;
        cyc("call");
        chk("call.pc_lit", pc_o, 32'h100);
        idle();
        cyc("c1"); cyc("c2");
        ret_i = 1'b1;
        cyc("ret");
        chk("ret.pc_lit", pc_o, 32'h14);
        idle();

        // Overflow: five calls, four returns, then underflow
        redirect_i = 1'b1; redirect_pc_i = 32'h0;
        cyc("redir0");
        idle();
        for (int i = 1; i <= 5; i++) begin
            call_i = 1'b1; target_i = 32'(i) * 32'h100;
            cyc("ovf_call");
        end
        chk("ovf.full_lit", {31'd0, ras_full_o}, 32'd1);
        call_i = 1'b0; ret_i = 1'b1;
        for (int i = 4; i >= 1; i--) begin
            cyc("ovf_ret");
            chk("ovf_ret.pc_lit", pc_o, 32'(i) * 32'h100 + 32'd4);
        end
        cyc("uf_ret");
        chk("uf.pulse_lit", {31'd0, ras_underflow_o}, 32'd1);
        idle();
        cyc("uf_clear");

        // Priority checks
        call_i = 1'b1; target_i = 32'h300;
        cyc("pre_exc");
        exc_i = 1'b1; redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h40;
        cyc("exc_prio");
        chk("exc.pc_lit", pc_o, 32'h80);
        idle();
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h40;
        cyc("redir_stall");
        chk("redir.pc_lit", pc_o, 32'h40);
        idle();
        call_i = 1'b1; target_i = 32'h200;
        cyc("call2");
        ret_i = 1'b1;
        cyc("callret");
        chk("callret.pc_lit", pc_o, 32'h44);
        call_i = 1'b0;
        cyc("ret_replaced");
        chk("replaced.pc_lit", pc_o, 32'h204);
        call_i = 1'b1; ret_i = 1'b1;
        cyc("callret_empty");
        idle();
        pc_enable_i = 1'b0; call_i = 1'b1;
        cyc("en_low");
        idle();

        // Asynchronous reset between edges
        call_i = 1'b1; target_i = 32'h700;
        cyc("pre_arst");
        idle();
        #3 rst_i = 1'b0;
        #1;
        model_reset();
        chk_all("arst");
        chk("arst.count_lit", {29'd0, ras_count_o}, 32'd0);
        @(negedge clk);
        rst_i = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC;
        cyc("wrap_redir");
        idle();
        cyc("wrap");
        chk("wrap.pc_lit", pc_o, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            start_i       = ($urandom_range(0, 49) != 0);
            exc_i         = ($urandom_range(0, 39) == 0);
            redirect_i    = ($urandom_range(0, 14) == 0);
            redirect_pc_i = $urandom & 32'hFFFF_FFFC;
            stall_i       = ($urandom_range(0, 7) == 0);
            pc_enable_i   = ($urandom_range(0, 9) != 0);
            call_i        = ($urandom_range(0, 3) == 0);
            ret_i         = ($urandom_range(0, 3) == 0);
            target_i      = $urandom & 32'hFFFF_FFFC;
            cyc("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised successor to the pipeline program-counter register.
- Holds the fetch PC and selects the next PC by fixed priority: exception vector, resolved-branch redirect, hazard stall, call/return, sequential increment.
- Contains a small circular return-address stack (RAS) that predicts `ret` targets.
- Sits at the head of the IF stage; feeds instruction-memory address and the IF/ID pc+step value.

Parameters:
- PC_W, 32: PC width in bits.
- RESET_PC, 0: PC value at reset and while start_i is low.
- INSTR_BYTES, 4: sequential increment.
- EXC_VECTOR, 32'h0000_0080: exception entry PC, truncated to PC_W.
- RAS_DEPTH, 4: RAS entries, 2 or more, power of two.

Ports:
- clk_i  in  1  clock, all state on rising edge
- rst_i  in  1  asynchronous, active-low reset
- start_i  in  1  CPU run enable; low holds the unit in the start state
- stall_i  in  1  hazard-detect stall; holds PC and RAS
- pc_enable_i  in  1  fetch enable; low holds PC and RAS
- exc_i  in  1  exception taken
- redirect_i  in  1  branch/jump resolved; load redirect_pc_i
- redirect_pc_i  in  PC_W  redirect target
- call_i  in  1  current fetch is a call
- ret_i  in  1  current fetch is a return
- target_i  in  PC_W  call target
- pc_o  out  PC_W  current fetch PC (registered)
- pc_plus_o  out  PC_W  pc_o + INSTR_BYTES (combinational)
- ras_count_o  out  $clog2(RAS_DEPTH+1)  valid RAS entries (registered)
- ras_empty_o  out  1  ras_count_o == 0
- ras_full_o  out  1  ras_count_o == RAS_DEPTH
- ras_underflow_o  out  1  registered one-cycle pulse: ret with empty RAS

Behaviour:
- Reset (rst_i low, asynchronous):
  - pc_o = RESET_PC, ras_count_o = 0, RAS pointer = 0, ras_underflow_o = 0.
  - RAS contents are don't-care.
- start_i low at an edge: same values as reset, loaded synchronously. Overrides every other input.
- start_i high: exactly one action per edge, first match wins:
  1. exc_i: pc <= EXC_VECTOR; RAS cleared (count 0). Ignores stall_i and pc_enable_i.
  2. redirect_i: pc <= redirect_pc_i; RAS unchanged. Ignores stall_i and pc_enable_i.
  3. stall_i: hold pc, hold RAS; call_i/ret_i ignored.
  4. pc_enable_i low: hold pc and RAS; call_i/ret_i ignored.
  5. call_i and ret_i together:
     - RAS non-empty: pc <= top entry; top overwritten with pc_plus_o; count unchanged.
     - RAS empty: push pc_plus_o, pc <= pc_plus_o, ras_underflow_o pulses.
  6. call_i: push pc_plus_o; pc <= target_i.
     - When full, the push overwrites the oldest entry (circular); count stays RAS_DEPTH.
  7. ret_i:
     - Non-empty: pc <= top entry, pop.
     - Empty: pc <= pc_plus_o, ras_underflow_o = 1 for one cycle.
  8. Otherwise: pc <= pc_plus_o.
- Arithmetic: all PC addition is modulo 2^PC_W; 0xFFFFFFFC + 4 wraps to 0.
- ras_underflow_o is 0 in every cycle it is not set by rule 5 or rule 7.
- Latency: selected next PC appears on pc_o one edge after the inputs are sampled. pc_plus_o follows pc_o combinationally.
- RAS storage:
  - Pointer advances modulo RAS_DEPTH on push and retreats on pop.
  - Count saturates at RAS_DEPTH and floors at 0.
  - No pointer or count movement on hold cycles.

Decomposition:
- Package pc_pkg:
  - next-PC select enum: SEL_RESET, SEL_EXC, SEL_REDIR, SEL_HOLD, SEL_CALLRET, SEL_CALL, SEL_RET, SEL_SEQ.
  - RAS op enum: NOP, PUSH, POP, REPLACE, CLEAR.
- Sub-module pc_ras: circular stack with pointer, count, full/empty, and a single op input.
- pc_unit keeps the priority decoder and the PC register.

Test Plan (PC_W=32, RESET_PC=0, INSTR_BYTES=4, RAS_DEPTH=4, EXC_VECTOR=0x80):
- Reset and run: rst_i low, then release with start_i=1, pc_enable_i=1 -> pc_o 0,4,8,0xC on successive edges; drop start_i -> pc_o returns to 0 next edge.
- Stall: at pc_o=8 hold stall_i two cycles with call_i=1 -> pc_o stays 8,8; ras_count_o stays 0; next edge pc_o=0xC.
- Call/return:
  - pc_o=0x10, call_i with target_i=0x100 -> pc_o=0x100, count 1.
  - Two sequential cycles, then ret_i at pc_o=0x108 -> pc_o=0x14, count 0.
- Overflow/underflow:
  - Five calls from pc 0x0, 0x100, 0x200, 0x300, 0x400 -> count 4, ras_full_o=1.
  - Four rets -> pc_o 0x404, 0x304, 0x204, 0x104.
  - Fifth ret -> pc_o = pc+4, ras_underflow_o high exactly one cycle.
- Priority:
  - exc_i, redirect_i, stall_i and call_i together -> pc_o=0x80, count 0.
  - redirect_i with stall_i, redirect_pc_i=0x40 -> pc_o=0x40.
  - call_i with ret_i on non-empty RAS -> pc_o = old top, count unchanged.
- Async reset mid-run and wrap:
  - rst_i low between edges -> pc_o=0 and count 0 immediately, without a clock edge.
  - After restart, redirect to 0xFFFFFFFC -> next sequential pc_o=0x0.
